// File: rtl/dioptase_mem_pkg.sv
// ----------------------------------------------------------------------------
// dioptase_mem_pkg
// Shared types and defaults for the memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT_IF, GRANT_DM, DONE)
//   grant_t     : which requester owns the next memory access
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   STREAK_W    : width of the DM streak counter (holds 0..15)
// ----------------------------------------------------------------------------
package dioptase_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STREAK_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    // True while a memory access is outstanding.
    function automatic logic is_grant_state(input arb_state_t st);
        return (st == GRANT_IF) || (st == GRANT_DM);
    endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// ----------------------------------------------------------------------------
// mem_arb_fairness
// Priority decision between instruction fetch and data memory requests.
// DM normally wins (it belongs to the older instruction), but after
// MAX_DM_STREAK consecutive DM grants taken while IF was waiting, IF is
// given the next turn so fetch can never starve.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   if_req     : fetch request pending
//   dm_req     : load/store request pending
//   grant_en   : strobe, a grant is being issued this cycle
//   grant      : requester chosen for the current cycle
// ----------------------------------------------------------------------------
module mem_arb_fairness
    import dioptase_mem_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   grant_en,
    output grant_t grant
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    logic [STREAK_W-1:0] streak_r;
    grant_t              grant_s;

    // Priority decision: DM first unless IF has waited out a full streak.
    always_comb begin
        grant_s = GNT_IF;
        if (dm_req && !(if_req && (streak_r == STREAK_MAX))) begin
            grant_s = GNT_DM;
        end else begin
            grant_s = GNT_IF;
        end
    end

    assign grant = grant_s;

    // Streak counter: counts DM grants that bypassed a waiting IF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_r <= {STREAK_W{1'b0}};
        end else if (grant_en) begin
            if ((grant_s == GNT_DM) && if_req) begin
                if (streak_r < STREAK_MAX) begin
                    streak_r <= streak_r + {{(STREAK_W-1){1'b0}}, 1'b1};
                end else begin
                    streak_r <= streak_r;
                end
            end else begin
                streak_r <= {STREAK_W{1'b0}};
            end
        end else begin
            streak_r <= streak_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between instruction
// fetch (IF) and the load/store stage (DM). Requesters use req/done, the
// memory side uses req/ack. One access is outstanding at a time:
//   IDLE -> GRANT_IF/GRANT_DM (command registered onto mem_*) -> DONE -> IDLE
// Optional feature (macro MEM_ARB_TIMEOUT_EN): a watchdog aborts an access
// after TIMEOUT_CYCLES without mem_ack, returns zero data, and sets the
// sticky arb_err output. Without the macro there is no arb_err port.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   if_req/if_addr                    : fetch request and address
//   if_rdata/if_done/if_stall         : fetch data, done pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be : load/store request
//   dm_rdata/dm_done/dm_stall         : load data, done pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : registered memory command
//   mem_ack/mem_rdata                 : memory completion and read data
//   arb_err                           : sticky timeout flag (optional)
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import dioptase_mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MAX_DM_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                arb_err
`endif
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state_r;
    arb_state_t          next_state_s;
    grant_t              grant_s;
    logic                grant_en_s;
    logic                timeout_s;

    logic                mem_req_d;
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic [BE_W-1:0]     mem_be_d;
    logic                if_done_d;
    logic                dm_done_d;
    logic [DATA_W-1:0]   if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_d;

    // Requests are only sampled in IDLE, which keeps DONE from re-granting.
    assign grant_en_s = (state_r == IDLE) && (if_req || dm_req);

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    mem_arb_fairness #(
        .MAX_DM_STREAK (MAX_DM_STREAK)
    ) u_fairness (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .grant_en (grant_en_s),
        .grant    (grant_s)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_r;

    // Watchdog: counts cycles spent waiting for mem_ack in a grant state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (is_grant_state(state_r) && !mem_ack) begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Fires on the edge that closes the TIMEOUT_CYCLES-th unanswered cycle.
    assign timeout_s = is_grant_state(state_r) && !mem_ack &&
                       (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_err <= 1'b0;
        end else if (timeout_s) begin
            arb_err <= 1'b1;
        end else begin
            arb_err <= arb_err;
        end
    end
`else
    logic unused_timeout_s;

    assign timeout_s        = 1'b0;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            mem_be    <= {BE_W{1'b0}};
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= {DATA_W{1'b0}};
            dm_rdata  <= {DATA_W{1'b0}};
        end else begin
            state_r   <= next_state_s;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_be    <= mem_be_d;
            if_done   <= if_done_d;
            dm_done   <= dm_done_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_en_s) begin
                    next_state_s = (grant_s == GNT_DM) ? GRANT_DM : GRANT_IF;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT_IF, GRANT_DM: begin
                if (mem_ack || timeout_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output logic: next values for the registered command, data and pulses.
    always_comb begin
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_en_s) begin
                    mem_req_d = 1'b1;
                    if (grant_s == GNT_DM) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_be_d    = dm_be;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = {DATA_W{1'b0}};
                        mem_be_d    = {BE_W{1'b0}};
                    end
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            GRANT_IF: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_done_d  = 1'b1;
                end else if (timeout_s) begin
                    mem_req_d  = 1'b0;
                    if_rdata_d = {DATA_W{1'b0}};
                    if_done_d  = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            GRANT_DM: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    dm_rdata_d = mem_rdata;
                    dm_done_d  = 1'b1;
                end else if (timeout_s) begin
                    mem_req_d  = 1'b0;
                    dm_rdata_d = {DATA_W{1'b0}};
                    dm_done_d  = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            DONE:    mem_req_d = 1'b0;
            default: mem_req_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (MAX_DM_STREAK=4,
// TIMEOUT_CYCLES=8). A vector table covers single accesses and the
// IDLE/DONE corner cases; hand-written sequences cover streak fairness,
// a long-latency store, mid-access reset and (with MEM_ARB_TIMEOUT_EN)
// the watchdog.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        arb_err;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .MAX_DM_STREAK  (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .dm_stall  (dm_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .arb_err   (arb_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_be;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic        e_if_done;
        logic        e_dm_done;
        logic        chk_rd;
        logic [31:0] e_rdata;
        logic        e_if_stall;
        logic        e_dm_stall;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dwe, input logic [31:0] da,
        input logic [31:0] dwd, input logic [3:0] dbe,
        input logic ack, input logic [31:0] rd,
        input logic emr, input logic emw, input logic [31:0] ema,
        input logic eid, input logic edd, input logic crd, input logic [31:0] erd,
        input logic eis, input logic eds);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;
        v.dm_req = dr;  v.dm_we = dwe; v.dm_addr = da; v.dm_wdata = dwd; v.dm_be = dbe;
        v.mem_ack = ack; v.mem_rdata = rd;
        v.e_mem_req = emr; v.e_mem_we = emw; v.e_mem_addr = ema;
        v.e_if_done = eid; v.e_dm_done = edd; v.chk_rd = crd; v.e_rdata = erd;
        v.e_if_stall = eis; v.e_dm_stall = eds;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for mem_req, checks the granted address, then acks it.
    task automatic serve_grant(input string name, input logic [31:0] exp_addr);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({name, ".granted"}, {31'd0, mem_req}, 32'd1);
        chk({name, ".addr"}, mem_addr, exp_addr);
        mem_ack   = 1'b1;
        mem_rdata = exp_addr ^ 32'hA5A5_0000;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] order[10];

        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_be = 4'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;

        // Vector table: inputs applied, one clock, outputs compared.
        vecs[0]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,          4'h0, 1'b1, 32'h5555_5555,
                      1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,          4'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,          4'h0, 1'b0, 32'h0,
                      1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,          4'h0, 1'b0, 32'h0,
                      1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,          4'h0, 1'b1, 32'hDEAD_BEEF,
                      1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF,  1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,          4'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,          4'h0, 1'b0, 32'h0,
                      1'b1, 1'b0, 32'h40,  1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0);
        vecs[7]  = mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,          4'h0, 1'b1, 32'hCAFE_0001,
                      1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'hCAFE_0001,  1'b0, 1'b0);
        // New DM request arriving in DONE must wait for IDLE.
        vecs[8]  = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'hAAAA_5555, 4'hF, 1'b0, 32'h0,
                      1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'hAAAA_5555, 4'hF, 1'b0, 32'h0,
                      1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1);
        vecs[10] = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'hAAAA_5555, 4'hF, 1'b1, 32'h0,
                      1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0);
        vecs[11] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,          4'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0);

        // Reset values.
        tick();
        chk("rst.mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst.mem_we",    {31'd0, mem_we},  32'd0);
        chk("rst.mem_addr",  mem_addr,  32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.mem_be",    {28'd0, mem_be}, 32'd0);
        chk("rst.if_done",   {31'd0, if_done}, 32'd0);
        chk("rst.dm_done",   {31'd0, dm_done}, 32'd0);
        chk("rst.if_rdata",  if_rdata, 32'd0);
        chk("rst.dm_rdata",  dm_rdata, 32'd0);
`ifdef MEM_ARB_TIMEOUT_EN
        chk("rst.arb_err",   {31'd0, arb_err}, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if_req = vecs[i].if_req;  if_addr = vecs[i].if_addr;
            dm_req = vecs[i].dm_req;  dm_we = vecs[i].dm_we; dm_addr = vecs[i].dm_addr;
            dm_wdata = vecs[i].dm_wdata; dm_be = vecs[i].dm_be;
            mem_ack = vecs[i].mem_ack; mem_rdata = vecs[i].mem_rdata;
            tick();
            chk($sformatf("vec%0d.mem_req", i),  {31'd0, mem_req},  {31'd0, vecs[i].e_mem_req});
            chk($sformatf("vec%0d.if_done", i),  {31'd0, if_done},  {31'd0, vecs[i].e_if_done});
            chk($sformatf("vec%0d.dm_done", i),  {31'd0, dm_done},  {31'd0, vecs[i].e_dm_done});
            chk($sformatf("vec%0d.if_stall", i), {31'd0, if_stall}, {31'd0, vecs[i].e_if_stall});
            chk($sformatf("vec%0d.dm_stall", i), {31'd0, dm_stall}, {31'd0, vecs[i].e_dm_stall});
            if (vecs[i].e_mem_req) begin
                chk($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].e_mem_addr);
                chk($sformatf("vec%0d.mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_mem_we});
            end
            if (vecs[i].chk_rd && vecs[i].e_if_done) begin
                chk($sformatf("vec%0d.if_rdata", i), if_rdata, vecs[i].e_rdata);
            end
            if (vecs[i].chk_rd && vecs[i].e_dm_done) begin
                chk($sformatf("vec%0d.dm_rdata", i), dm_rdata, vecs[i].e_rdata);
            end
        end
        mem_ack = 1'b0;

        // Fairness: both requesters held, expect D D D D I D D D D I.
        order = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000,
                  32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000};
        if_req = 1'b1; if_addr = 32'h1000;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        for (int g = 0; g < 10; g++) begin
            serve_grant($sformatf("streak%0d", g), order[g]);
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick();

        // Store with ack delayed 10 cycles; inputs change after grant.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'h1234_5678; dm_be = 4'b0011;
        tick();
        dm_addr = 32'hFFFF_0000; dm_wdata = 32'h0; dm_be = 4'hF; dm_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("st%0d.mem_req", k),   {31'd0, mem_req},  32'd1);
            chk($sformatf("st%0d.mem_we", k),    {31'd0, mem_we},   32'd1);
            chk($sformatf("st%0d.mem_addr", k),  mem_addr,          32'h300);
            chk($sformatf("st%0d.mem_wdata", k), mem_wdata,         32'h1234_5678);
            chk($sformatf("st%0d.mem_be", k),    {28'd0, mem_be},   32'h3);
            chk($sformatf("st%0d.dm_stall", k),  {31'd0, dm_stall}, 32'd1);
            chk($sformatf("st%0d.dm_done", k),   {31'd0, dm_done},  32'd0);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        chk("st.done",     {31'd0, dm_done},  32'd1);
        chk("st.mem_req",  {31'd0, mem_req},  32'd0);
        chk("st.dm_stall", {31'd0, dm_stall}, 32'd0);
        mem_ack = 1'b0; dm_req = 1'b0;
        tick();
        chk("st.done_end", {31'd0, dm_done}, 32'd0);

        // Reset in the middle of an IF access.
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        chk("rstmid.granted", {31'd0, mem_req}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("rstmid.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid.if_done", {31'd0, if_done}, 32'd0);
        #2 rst = 1'b0;
        tick();
        chk("rstmid.regrant", {31'd0, mem_req}, 32'd1);
        chk("rstmid.addr",    mem_addr, 32'h500);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        chk("rstmid.if_done2", {31'd0, if_done}, 32'd1);
        chk("rstmid.if_rdata", if_rdata, 32'h0BAD_F00D);
        mem_ack = 1'b0; if_req = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: mem_ack never comes.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
        tick();
        chk("to.granted", {31'd0, mem_req}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("to%0d.mem_req", k), {31'd0, mem_req}, 32'd1);
            chk($sformatf("to%0d.dm_done", k), {31'd0, dm_done}, 32'd0);
        end
        tick();
        chk("to.dm_done",  {31'd0, dm_done}, 32'd1);
        chk("to.dm_rdata", dm_rdata, 32'd0);
        chk("to.mem_req",  {31'd0, mem_req}, 32'd0);
        chk("to.arb_err",  {31'd0, arb_err}, 32'd1);
        dm_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("to.sticky%0d", k), {31'd0, arb_err}, 32'd1);
        end
        rst = 1'b1;
        #1;
        chk("to.err_clr", {31'd0, arb_err}, 32'd0);
        rst = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
